// File: rtl/frame_burst_sched_pkg.sv
// Shared types and default geometry for the SDRAM frame burst scheduler.
package frame_sched_pkg;

    typedef enum logic [1:0] {
        ST_ARB  = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2
    } sched_state_t;

    localparam logic CMD_RD = 1'b0;
    localparam logic CMD_WR = 1'b1;

    localparam int unsigned DEF_ADDR_W      = 24;
    localparam int unsigned DEF_CNT_W       = 10;
    localparam int unsigned DEF_BURST_LEN   = 256;
    localparam int unsigned DEF_FRAME_W     = 1024;
    localparam int unsigned DEF_FRAME_H     = 768;
    localparam int unsigned DEF_FRAME_WORDS = DEF_FRAME_W * DEF_FRAME_H;

endpackage

// File: rtl/frame_burst_sched_if.sv
// Burst command port between the scheduler (master) and the SDRAM controller (slave).
interface frame_burst_sched_if
    import frame_sched_pkg::*;
#(
    parameter int unsigned ADDR_W = DEF_ADDR_W
);
    logic              cmd_req;
    logic              cmd_wr;
    logic [ADDR_W-1:0] cmd_addr;
    logic              cmd_ack;
    logic              cmd_done;

    modport master (
        output cmd_req, cmd_wr, cmd_addr,
        input  cmd_ack, cmd_done
    );

    modport slave (
        input  cmd_req, cmd_wr, cmd_addr,
        output cmd_ack, cmd_done
    );
endinterface

// File: rtl/frame_burst_sched_chan_cnt.sv
// Per-channel frame offset counter with frame-complete flag.
module sched_chan_cnt
    import frame_sched_pkg::*;
#(
    parameter int unsigned OFF_W       = $clog2(DEF_FRAME_WORDS) + 1,
    parameter int unsigned BURST_LEN   = DEF_BURST_LEN,
    parameter int unsigned FRAME_WORDS = DEF_FRAME_WORDS
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             advance,
    output logic [OFF_W-1:0] off,
    output logic             done
);
    logic [OFF_W-1:0] off_next;

    assign off_next = off + OFF_W'(BURST_LEN);

    // Done comes out of reset set so no traffic starts before the first swap.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            off  <= '0;
            done <= 1'b1;
        end else if (clear) begin
            off  <= '0;
            done <= 1'b0;
        end else if (advance) begin
            off <= off_next;
            if (off_next == OFF_W'(FRAME_WORDS)) begin
                done <= 1'b1;
            end
        end
    end
endmodule

// File: rtl/frame_burst_sched.sv
// Burst-granular SDRAM arbiter between camera write and VGA read FIFOs,
// addressing two ping-pong frame buffers that swap on frame_start.
module frame_burst_sched
    import frame_sched_pkg::*;
#(
    parameter int unsigned ADDR_W        = DEF_ADDR_W,
    parameter int unsigned CNT_W         = DEF_CNT_W,
    parameter int unsigned BURST_LEN     = DEF_BURST_LEN,
    parameter int unsigned FRAME_WORDS   = DEF_FRAME_WORDS,
    parameter int unsigned BUF0_BASE     = 0,
    parameter int unsigned BUF1_BASE     = 1048576,
    parameter int unsigned RD_FIFO_DEPTH = 512,
    parameter int unsigned WR_URGENT     = 384
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 frame_start,
    input  logic [CNT_W-1:0]     wr_fifo_cnt,
    input  logic [CNT_W-1:0]     rd_fifo_cnt,
    frame_burst_sched_if.master  cmd,
    output logic                 buf_sel,
    output logic                 wr_frame_done,
    output logic                 rd_frame_done,
    output logic                 frame_overrun,
    output logic                 busy
);
    localparam int unsigned OFF_W = $clog2(FRAME_WORDS) + 1;

    localparam logic [CNT_W:0] BURST_C   = (CNT_W+1)'(BURST_LEN);
    localparam logic [CNT_W:0] URGENT_C  = (CNT_W+1)'(WR_URGENT);
    localparam logic [CNT_W:0] RD_DEPTH  = (CNT_W+1)'(RD_FIFO_DEPTH);

    if ((FRAME_WORDS % BURST_LEN) != 0) begin : g_chk_frame
        $error("FRAME_WORDS must be a multiple of BURST_LEN");
    end
    if ((BURST_LEN & (BURST_LEN - 1)) != 0) begin : g_chk_burst
        $error("BURST_LEN must be a power of two");
    end

    sched_state_t      state_q, state_d;
    logic              cmd_wr_q;
    logic [ADDR_W-1:0] cmd_addr_q;
    logic              buf_sel_q;
    logic              pending_q;
    logic              overrun_q;

    logic              swap, grant, grant_wr, adv_wr, adv_rd;
    logic              wr_elig, rd_elig, wr_urgent;
    logic [CNT_W:0]    rd_space;
    logic [OFF_W-1:0]  wr_off, rd_off;
    logic              wr_done, rd_done;
    logic [ADDR_W-1:0] wr_addr, rd_addr, grant_addr;

    sched_chan_cnt #(
        .OFF_W       (OFF_W),
        .BURST_LEN   (BURST_LEN),
        .FRAME_WORDS (FRAME_WORDS)
    ) u_wr_cnt (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (swap),
        .advance (adv_wr),
        .off     (wr_off),
        .done    (wr_done)
    );

    sched_chan_cnt #(
        .OFF_W       (OFF_W),
        .BURST_LEN   (BURST_LEN),
        .FRAME_WORDS (FRAME_WORDS)
    ) u_rd_cnt (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (swap),
        .advance (adv_rd),
        .off     (rd_off),
        .done    (rd_done)
    );

    assign rd_space  = RD_DEPTH - {1'b0, rd_fifo_cnt};
    assign wr_elig   = !wr_done && ({1'b0, wr_fifo_cnt} >= BURST_C);
    assign wr_urgent = {1'b0, wr_fifo_cnt} >= URGENT_C;
    assign rd_elig   = !rd_done && (rd_space >= BURST_C);

    // Writer fills buf_sel; reader drains the other buffer.
    assign wr_addr = (buf_sel_q ? ADDR_W'(BUF1_BASE) : ADDR_W'(BUF0_BASE)) + ADDR_W'(wr_off);
    assign rd_addr = (buf_sel_q ? ADDR_W'(BUF0_BASE) : ADDR_W'(BUF1_BASE)) + ADDR_W'(rd_off);
    assign grant_addr = grant_wr ? wr_addr : rd_addr;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_ARB;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        swap     = 1'b0;
        grant    = 1'b0;
        grant_wr = CMD_RD;
        adv_wr   = 1'b0;
        adv_rd   = 1'b0;
        case (state_q)
            ST_ARB: begin
                if (pending_q) begin
                    swap = 1'b1;
                end else if (wr_elig && wr_urgent) begin
                    grant    = 1'b1;
                    grant_wr = CMD_WR;
                end else if (rd_elig) begin
                    grant    = 1'b1;
                    grant_wr = CMD_RD;
                end else if (wr_elig) begin
                    grant    = 1'b1;
                    grant_wr = CMD_WR;
                end
                if (grant) begin
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                if (cmd.cmd_ack) begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (cmd.cmd_done) begin
                    state_d = ST_ARB;
                    adv_wr  = (cmd_wr_q == CMD_WR);
                    adv_rd  = (cmd_wr_q == CMD_RD);
                end
            end
            default: state_d = ST_ARB;
        endcase
    end

    // A frame_start coinciding with the swap re-arms pending for another swap.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cmd_wr_q   <= CMD_RD;
            cmd_addr_q <= '0;
            buf_sel_q  <= 1'b0;
            pending_q  <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            pending_q <= frame_start | (pending_q & ~swap);
            overrun_q <= swap & ~(wr_done & rd_done);
            if (swap) begin
                buf_sel_q <= ~buf_sel_q;
            end
            if (grant) begin
                cmd_wr_q   <= grant_wr;
                cmd_addr_q <= grant_addr;
            end
        end
    end

    assign cmd.cmd_req   = (state_q == ST_REQ);
    assign cmd.cmd_wr    = cmd_wr_q;
    assign cmd.cmd_addr  = cmd_addr_q;
    assign buf_sel       = buf_sel_q;
    assign wr_frame_done = wr_done;
    assign rd_frame_done = rd_done;
    assign frame_overrun = overrun_q;
    assign busy          = (state_q != ST_ARB);
endmodule

// File: tb/tb_frame_burst_sched.sv
// Directed + randomized bench for frame_burst_sched against a transaction-level frame model.
module tb_frame_burst_sched;
    localparam int unsigned BL    = 256;
    localparam int unsigned FW    = 786432;
    localparam int unsigned B0    = 0;
    localparam int unsigned B1    = 1048576;
    localparam int unsigned DEPTH = 512;
    localparam int unsigned URG   = 384;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       frame_start;
    logic [9:0] wr_fifo_cnt;
    logic [9:0] rd_fifo_cnt;
    logic       buf_sel, wr_frame_done, rd_frame_done, frame_overrun, busy;

    frame_burst_sched_if #(.ADDR_W(24)) bus ();

    frame_burst_sched #(
        .ADDR_W        (24),
        .CNT_W         (10),
        .BURST_LEN     (BL),
        .FRAME_WORDS   (FW),
        .BUF0_BASE     (B0),
        .BUF1_BASE     (B1),
        .RD_FIFO_DEPTH (DEPTH),
        .WR_URGENT     (URG)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .frame_start   (frame_start),
        .wr_fifo_cnt   (wr_fifo_cnt),
        .rd_fifo_cnt   (rd_fifo_cnt),
        .cmd           (bus),
        .buf_sel       (buf_sel),
        .wr_frame_done (wr_frame_done),
        .rd_frame_done (rd_frame_done),
        .frame_overrun (frame_overrun),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;
    int n_ovr    = 0;

    always @(negedge clk) if (frame_overrun === 1'b1) n_ovr++;

    // Frame-level reference state
    bit m_buf, m_wr_done, m_rd_done, m_pending;
    int m_wr_off, m_rd_off, m_ovr;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_buf = 0; m_wr_off = 0; m_rd_off = 0;
        m_wr_done = 1; m_rd_done = 1; m_pending = 0;
    endtask

    task automatic model_swap();
        if (!m_wr_done || !m_rd_done) m_ovr++;
        m_buf = !m_buf; m_wr_off = 0; m_rd_off = 0;
        m_wr_done = 0; m_rd_done = 0; m_pending = 0;
    endtask

    task automatic pulse_fs();
        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
        m_pending = 1;
    endtask

    // mode 0: plain burst, 1: two frame_starts while waiting, 2: reset while waiting
    task automatic do_burst(input int wc, input int rc, input int mode, output int addr_seen);
        bit wr_ok, rd_ok, exp_any, exp_wr, got, seen;
        int exp_addr, hold;
        addr_seen = -1;
        wr_fifo_cnt = 10'(wc);
        rd_fifo_cnt = 10'(rc);
        if (m_pending) model_swap();
        wr_ok = !m_wr_done && (wc >= BL);
        rd_ok = !m_rd_done && ((DEPTH - rc) >= BL);
        exp_any = wr_ok || rd_ok;
        exp_wr  = (wr_ok && wc >= URG) || (wr_ok && !rd_ok);
        if (!exp_any) begin
            seen = 0;
            for (int i = 0; i < 8; i++) begin
                bus.cmd_done = (i == 2);
                @(negedge clk);
                if (bus.cmd_req === 1'b1) seen = 1;
            end
            bus.cmd_done = 1'b0;
            chk("idle_no_req", seen, 0);
            chk("idle_buf_sel", buf_sel, m_buf);
            chk("idle_wr_done", wr_frame_done, m_wr_done);
            chk("idle_rd_done", rd_frame_done, m_rd_done);
            chk("ovr_count", n_ovr, m_ovr);
            return;
        end
        exp_addr = exp_wr ? ((m_buf ? B1 : B0) + m_wr_off) : ((m_buf ? B0 : B1) + m_rd_off);
        got = 0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            got = (bus.cmd_req === 1'b1);
        end
        chk("req_seen", got, 1);
        if (!got) return;
        chk("cmd_wr", bus.cmd_wr, exp_wr);
        chk("cmd_addr", bus.cmd_addr, exp_addr);
        chk("buf_sel", buf_sel, m_buf);
        chk("busy_req", busy, 1);
        chk("ovr_count", n_ovr, m_ovr);
        addr_seen = int'(bus.cmd_addr);
        hold = $urandom_range(0, 2);
        repeat (hold) @(negedge clk);
        chk("req_held", bus.cmd_req, 1);
        chk("addr_held", bus.cmd_addr, exp_addr);
        bus.cmd_ack  = 1'b1;
        bus.cmd_done = ($urandom_range(0, 3) == 0);
        @(negedge clk);
        bus.cmd_ack  = 1'b0;
        bus.cmd_done = 1'b0;
        chk("req_drop", bus.cmd_req, 0);
        chk("busy_wait", busy, 1);
        repeat ($urandom_range(0, 3)) @(negedge clk);
        if (mode == 1) begin
            pulse_fs();
            @(negedge clk);
            pulse_fs();
            chk("swap_deferred", buf_sel, m_buf);
            chk("busy_fs_wait", busy, 1);
        end
        if (mode == 2) begin
            rst_n = 1'b0;
            @(negedge clk);
            rst_n = 1'b1;
            model_reset();
        end
        bus.cmd_done = 1'b1;
        @(negedge clk);
        bus.cmd_done = 1'b0;
        if (mode != 2) begin
            if (exp_wr) begin
                m_wr_off += BL;
                if (m_wr_off == FW) m_wr_done = 1;
            end else begin
                m_rd_off += BL;
                if (m_rd_off == FW) m_rd_done = 1;
            end
        end
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: time limit reached before end of test");
        $fatal(1);
    end

    initial begin
        int a, last, seen, iter;
        rst_n = 1'b0; frame_start = 1'b0;
        wr_fifo_cnt = 10'd500; rd_fifo_cnt = 10'd0;
        bus.cmd_ack = 1'b0; bus.cmd_done = 1'b0;
        m_ovr = 0;
        model_reset();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Idle after reset: done flags block all traffic
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus.cmd_req === 1'b1) seen = 1;
        end
        chk("rst_no_req", seen, 0);
        chk("rst_cmd_wr", bus.cmd_wr, 0);
        chk("rst_cmd_addr", bus.cmd_addr, 0);
        chk("rst_buf_sel", buf_sel, 0);
        chk("rst_wr_done", wr_frame_done, 1);
        chk("rst_rd_done", rd_frame_done, 1);
        chk("rst_overrun", frame_overrun, 0);
        chk("rst_busy", busy, 0);

        // First frame: read wins over non-urgent write, then write
        pulse_fs();
        do_burst(256, 0, 0, a);
        chk("first_read_addr", a, B0);
        do_burst(256, 512, 0, a);
        chk("first_write_addr", a, B1);
        do_burst(400, 0, 0, a);
        chk("urgent_write_addr", a, B1 + BL);

        // Randomized levels
        for (int i = 0; i < 40; i++) begin
            do_burst($urandom_range(0, 1023), $urandom_range(0, 512), 0, a);
        end

        // Complete the write frame
        last = -1; iter = 0;
        while (!m_wr_done && iter < 4000) begin
            do_burst($urandom_range(256, 1023), 512, 0, a);
            last = a;
            iter++;
        end
        chk("final_write_addr", last, B1 + FW - BL);
        chk("wr_frame_done", wr_frame_done, 1);
        do_burst(1000, 512, 0, a);

        // Swap requested mid-burst applies after completion, with overrun
        do_burst(0, 0, 1, a);
        do_burst(400, 512, 0, a);
        chk("swap_write_base", a, B0);
        chk("overrun_once", n_ovr, 1);

        // Reset while waiting; stale cmd_done ignored
        do_burst(400, 512, 2, a);
        chk("rrst_req", bus.cmd_req, 0);
        chk("rrst_busy", busy, 0);
        chk("rrst_cmd_wr", bus.cmd_wr, 0);
        chk("rrst_cmd_addr", bus.cmd_addr, 0);
        chk("rrst_buf_sel", buf_sel, 0);
        chk("rrst_wr_done", wr_frame_done, 1);
        chk("rrst_rd_done", rd_frame_done, 1);
        chk("rrst_overrun", frame_overrun, 0);
        pulse_fs();
        do_burst(300, 512, 0, a);
        chk("post_rst_write_addr", a, B1);
        chk("overrun_total", n_ovr, 1);

        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
